pkt_rr_scheduler: RTL and testbench

- Shares one downstream flit channel among N upstream packet streams.
- Uses round-robin arbitration at packet granularity. A grant is held from the first flit to the last flit of a packet, so packets never interleave.
- Output is registered: one pipeline stage, full throughput of 1 flit/cycle.
- Sits in front of any shared egress resource, such as a memory write port or network link.

---
 rtl/pkt_rr_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pkt_rr_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_scheduler.sv
// -----------------------------------------------------------------------------
// pkt_rr_scheduler
//   Shares one downstream flit channel among N upstream packet streams.
//   Arbitration is round-robin at packet granularity: once the first flit of
//   a packet is accepted, the grant stays with that stream until its last
//   flit, so packets never interleave. The output is a single register stage
//   that sustains one flit per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   [N]     per-stream flit valid
//   in_ready_o   [N]     per-stream flit accept (combinational)
//   in_data_i    [N*DW]  stream i occupies bits [i*DW +: DW]
//   in_last_i    [N]     per-stream last-flit-of-packet marker
//   out_valid_o          output register holds a flit
//   out_ready_i          downstream accept
//   out_data_o   [DW]    registered flit data
//   out_last_o           registered last marker
//   out_src_o    [SW]    index of the stream that supplied out_data_o
//   busy_o               a packet is open or a flit is held
// -----------------------------------------------------------------------------
module pkt_rr_scheduler #(
    parameter int N  = 4,
    parameter int DW = 64,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid_i,
    output logic [N-1:0]    in_ready_o,
    input  logic [N*DW-1:0] in_data_i,
    input  logic [N-1:0]    in_last_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DW-1:0]   out_data_o,
    output logic            out_last_o,
    output logic [SW-1:0]   out_src_o,
    output logic            busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   last_grant_q, last_grant_d;
    logic [SW-1:0]   lock_id_q, lock_id_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [SW-1:0]   out_src_q, out_src_d;
    logic            busy_q, busy_d;

    logic            can_accept_s;
    logic [SW:0]     win_s;
    logic            grant_ok_s;
    logic [SW-1:0]   grant_id_s;
    logic            sel_valid_s;
    logic            sel_last_s;
    logic [DW-1:0]   sel_data_s;
    logic [N-1:0]    in_ready_s;
    logic            xfer_s;

    // Round-robin search starting just after the last granted stream.
    // Returns {found, index}; scanning from the far end and overwriting
    // leaves the nearest valid stream as the result.
    function automatic logic [SW:0] rr_pick(input logic [N-1:0] valid,
                                            input logic [SW-1:0] last);
        logic [SW:0]   res;
        logic [SW-1:0] pos;
        res = {(SW+1){1'b0}};
        for (int k = N; k >= 1; k--) begin
            pos = SW'((int'(last) + k) % N);
            res = valid[pos] ? {1'b1, pos} : res;
        end
        return res;
    endfunction

    // Grant selection, input mux and handshake generation.
    always_comb begin
        can_accept_s = ~out_valid_q | out_ready_i;
        win_s        = rr_pick(in_valid_i, last_grant_q);
        if (state_q == ST_LOCKED) begin
            // Locked stream keeps ready even while it bubbles.
            grant_ok_s = 1'b1;
            grant_id_s = lock_id_q;
        end else begin
            grant_ok_s = win_s[SW];
            grant_id_s = win_s[SW-1:0];
        end
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = {DW{1'b0}};
        in_ready_s  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_valid_s   = sel_valid_s | ((grant_id_s == SW'(i)) & in_valid_i[i]);
            sel_last_s    = sel_last_s  | ((grant_id_s == SW'(i)) & in_last_i[i]);
            sel_data_s    = sel_data_s  | ({DW{grant_id_s == SW'(i)}} & in_data_i[i*DW +: DW]);
            in_ready_s[i] = grant_ok_s & can_accept_s & (grant_id_s == SW'(i));
        end
        xfer_s = grant_ok_s & can_accept_s & sel_valid_s;
    end

    // Next-state logic for the packet FSM and the output register.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_id_d    = lock_id_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && sel_last_s) begin
                    last_grant_d = grant_id_s;
                end else if (xfer_s) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = grant_id_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    state_d      = ST_IDLE;
                    last_grant_d = lock_id_q;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_src_d  = out_src_q;
        if (xfer_s) begin
            // Reload also covers the drain-and-refill cycle.
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_last_d  = sel_last_s;
            out_src_d   = grant_id_s;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        busy_d = (state_d == ST_LOCKED) | out_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SW'(N - 1);
            lock_id_q    <= {SW{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            out_last_q   <= 1'b0;
            out_src_q    <= {SW{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_id_q    <= lock_id_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_src_q    <= out_src_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pkt_rr_scheduler
//   Directed scenarios plus a long random run for pkt_rr_scheduler (N=4,
//   DW=16). A packet-level model predicts handshakes and the output register
//   every cycle; a scoreboard, contiguity and fairness monitors watch the
//   DUT's own handshakes; literal expectations pin the directed scenarios.
//   Flit data encodes {stream[3:0], packet seq[7:0], flit index[3:0]}.
// -----------------------------------------------------------------------------
module tb_pkt_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int QD = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            busy;

    pkt_rr_scheduler #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus sources ----------------
    logic [16:0]  mem [N][QD];
    int           hd [N];
    int           tl [N];
    logic [7:0]   seq [N];
    logic [N-1:0] en;
    logic [N-1:0] gate;
    logic         rnd_mode;
    logic         ordy_fix;
    logic [N-1:0] xm_cap;

    task automatic add_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) begin
            mem[s][tl[s] % QD] = {(k == len - 1), 4'(s), seq[s], 4'(k)};
            tl[s]++;
        end
        seq[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hd[i] < tl[i] && en[i] && gate[i]) begin
                in_valid[i] = 1'b1;
                {in_last[i], in_data[i*DW +: DW]} = mem[i][hd[i] % QD];
            end else begin
                in_valid[i]          = 1'b0;
                in_last[i]           = 1'($urandom);
                in_data[i*DW +: DW]  = DW'($urandom);
            end
        end
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ordy_fix;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xm_cap[i]) hd[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i]  = 0;
            tl[i]  = 0;
            seq[i] = 8'h01;
        end
        en       = '1;
        gate     = '1;
        ordy_fix = 1'b1;
        rnd_mode = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        obs_src.delete();
        obs_dat.delete();
        rst_n = 1'b1;
        drive();
    endtask

    // Handshake seen just before each rising edge (what the edge will take).
    initial begin
        xm_cap = '0;
        forever begin
            @(negedge clk);
            xm_cap = rst_n ? (in_valid & in_ready) : '0;
        end
    end

    // ---------------- behavioural model ----------------
    int            m_owner = -1;      // stream holding an open packet, -1 none
    int            m_prev  = N - 1;   // stream granted most recently
    logic          m_full  = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_last  = 1'b0;
    int            m_src   = 0;

    function automatic logic [N-1:0] m_ready_f();
        int pick;
        logic [N-1:0] r;
        pick = -1;
        if (m_owner >= 0) pick = m_owner;
        else begin
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && in_valid[(m_prev + k) % N]) pick = (m_prev + k) % N;
            end
        end
        r = '0;
        if (pick >= 0 && (!m_full || out_ready)) r[pick] = 1'b1;
        return r;
    endfunction

    initial begin
        logic [N-1:0] t;
        int w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_prev = N - 1; m_full = 1'b0;
                m_data = '0; m_last = 1'b0; m_src = 0;
            end else begin
                t = m_ready_f() & in_valid;
                w = -1;
                for (int i = 0; i < N; i++) if (t[i]) w = i;
                if (w >= 0) begin
                    m_full = 1'b1;
                    m_data = in_data[w*DW +: DW];
                    m_last = in_last[w];
                    m_src  = w;
                    if (in_last[w]) begin
                        m_owner = -1;
                        m_prev  = w;
                    end else begin
                        m_owner = w;
                    end
                end else if (out_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Model comparison every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_in_ready",  in_ready,  m_ready_f());
            chk("m_out_valid", out_valid, m_full);
            chk("m_busy",      busy,      (m_owner >= 0) || m_full);
            chk("m_out_data",  out_data,  m_data);
            chk("m_out_last",  out_last,  m_last);
            chk("m_out_src",   out_src,   m_src[1:0]);
        end
    end

    // ---------------- scoreboard / contiguity / fairness ----------------
    logic [16:0]   sb [N][QD];
    int            sh [N];
    int            st [N];
    int            in_open  = -1;
    int            out_open = -1;
    int            waitc [N];
    int            obs_src [$];
    logic [DW-1:0] obs_dat [$];

    initial begin
        logic [N-1:0] hs;
        int s;
        for (int i = 0; i < N; i++) begin sh[i] = 0; st[i] = 0; waitc[i] = 0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin sh[i] = 0; st[i] = 0; waitc[i] = 0; end
                in_open  = -1;
                out_open = -1;
            end else begin
                if (out_valid && out_ready) begin
                    s = int'(out_src);
                    obs_src.push_back(s);
                    obs_dat.push_back(out_data);
                    chk("sb_has_flit", (st[s] > sh[s]), 1'b1);
                    if (st[s] > sh[s]) begin
                        chk("sb_flit", {out_last, out_data}, sb[s][sh[s] % QD]);
                        sh[s]++;
                    end
                    if (out_open >= 0) chk("out_contig", s, out_open);
                    out_open = out_last ? -1 : s;
                end
                hs = in_valid & in_ready;
                if (hs != '0) begin
                    chk("in_onehot", $countones(hs), 1);
                    for (int i = 0; i < N; i++) begin
                        if (hs[i]) begin
                            sb[i][st[i] % QD] = {in_last[i], in_data[i*DW +: DW]};
                            st[i]++;
                            if (in_open < 0) begin
                                for (int j = 0; j < N; j++) begin
                                    if (j == i) waitc[j] = 0;
                                    else begin
                                        waitc[j] = in_valid[j] ? waitc[j] + 1 : 0;
                                        chk("fair_wait", (waitc[j] > N - 1), 1'b0);
                                    end
                                end
                            end else begin
                                chk("in_interleave", i, in_open);
                            end
                            in_open = in_last[i] ? -1 : i;
                        end
                    end
                end
            end
        end
    end

    task automatic check_seq(input string nm, input int exp [8], input int n);
        chk({nm, "_len"}, obs_src.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < obs_src.size()) chk(nm, obs_src[k], exp[k]);
        end
    endtask

    // ---------------- directed scenarios and random run ----------------
    initial begin
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
        do_reset();
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_out_data",  out_data,  16'h0000);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_out_src",   out_src,   2'd0);
        chk("rst_in_ready",  in_ready,  4'b0000);

        // All streams send single-flit packets back to back.
        for (int s = 0; s < N; s++) begin add_pkt(s, 1); add_pkt(s, 1); end
        drive();
        #2;
        chk("t1_first_ready", in_ready, 4'b0001);
        chk("t1_no_out_yet",  out_valid, 1'b0);
        step();
        #2;
        chk("t1_lat_valid", out_valid, 1'b1);
        chk("t1_lat_src",   out_src,   2'd0);
        chk("t1_lat_data",  out_data,  16'h0010);
        repeat (7) step();
        chk("t1_rate", obs_src.size(), 7);
        repeat (3) step();
        check_seq("t1_order", '{0, 1, 2, 3, 0, 1, 2, 3}, 8);

        // 3-flit packet on stream 2 locks out stream 1.
        do_reset();
        add_pkt(2, 3);
        drive();
        #2 chk("t2_c0_ready", in_ready, 4'b0100);
        step();
        add_pkt(1, 1);
        drive();
        #2 chk("t2_c1_ready", in_ready, 4'b0100);
        step();
        #2 chk("t2_c2_ready", in_ready, 4'b0100);
        step();
        #2 chk("t2_c3_ready", in_ready, 4'b0010);
        repeat (4) step();
        check_seq("t2_order", '{2, 2, 2, 1, 0, 0, 0, 0}, 4);
        if (obs_dat.size() > 2) chk("t2_last_data", obs_dat[2], 16'h2012);

        // Downstream stall for 5 cycles with stream 0 valid.
        do_reset();
        ordy_fix = 1'b0;
        for (int p = 0; p < 4; p++) add_pkt(0, 1);
        drive();
        step();
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk("t3_stall_ready", in_ready,  4'b0000);
            chk("t3_stall_valid", out_valid, 1'b1);
            chk("t3_stall_data",  out_data,  16'h0010);
            step();
        end
        ordy_fix = 1'b1;
        drive();
        repeat (8) step();
        check_seq("t3_order", '{0, 0, 0, 0, 0, 0, 0, 0}, 4);
        if (obs_dat.size() == 4) begin
            chk("t3_d0", obs_dat[0], 16'h0010);
            chk("t3_d1", obs_dat[1], 16'h0020);
            chk("t3_d2", obs_dat[2], 16'h0030);
            chk("t3_d3", obs_dat[3], 16'h0040);
        end

        // Locked stream 3 bubbles for 4 cycles while stream 0 waits.
        do_reset();
        add_pkt(3, 3);
        drive();
        step();
        en[3] = 1'b0;
        add_pkt(0, 1);
        drive();
        #2 chk("t4_c1_ready", in_ready, 4'b1000);
        step();
        for (int c = 2; c <= 4; c++) begin
            #2;
            chk("t4_bub_valid", out_valid, 1'b0);
            chk("t4_bub_busy",  busy,      1'b1);
            chk("t4_bub_ready", in_ready,  4'b1000);
            step();
        end
        en[3] = 1'b1;
        drive();
        repeat (6) step();
        check_seq("t4_order", '{3, 3, 3, 0, 0, 0, 0, 0}, 4);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        add_pkt(1, 4);
        drive();
        step();
        step();
        #2 chk("t5_pre_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 1'b0);
        chk("t5_async_busy",  busy,      1'b0);
        do_reset();
        add_pkt(0, 1);
        add_pkt(1, 1);
        drive();
        #2 chk("t5_ready", in_ready, 4'b0001);
        repeat (4) step();
        check_seq("t5_order", '{0, 1, 0, 0, 0, 0, 0, 0}, 2);

        // Random traffic, then drain.
        do_reset();
        rnd_mode = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (tl[i] - hd[i] < 4) add_pkt(i, $urandom_range(1, 8));
                gate[i] = 1'($urandom_range(0, 1));
            end
            drive();
            step();
        end
        rnd_mode = 1'b0;
        ordy_fix = 1'b1;
        gate     = '1;
        drive();
        repeat (100) step();
        for (int i = 0; i < N; i++) begin
            chk("rnd_src_drained", tl[i] - hd[i], 0);
            chk("rnd_sb_drained",  st[i] - sh[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
